// File: rtl/decode_stage_pkg.sv
// mips_decode_pkg: opcodes, ALU op encoding and the decoded control bundle shared by the decode stage.
package mips_decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D;
    localparam logic [5:0] OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4,
        ALU_LUI = 4'd5
    } aluOpT;

    typedef struct packed {
        aluOpT      aluOp;
        logic [4:0] dest;
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       branch;
        logic       aluSrcImm;
    } ctrlT;

    function automatic logic [31:0] signExt16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side, register-bank and ID/EX-side signals of the decode stage.
interface decode_stage_if;
    import mips_decode_pkg::*;
    logic        ifValid;
    logic [31:0] ifInstr;
    logic [31:0] ifPc;
    logic        ifReady;
    logic        flush;
    logic [4:0]  rAddr1;
    logic [4:0]  rAddr2;
    logic [31:0] regData1;
    logic [31:0] regData2;
    logic        exValid;
    logic        exReady;
    logic [31:0] exPc;
    logic [31:0] exRs1Data;
    logic [31:0] exRs2Data;
    logic [31:0] exImm;
    logic [4:0]  exDest;
    aluOpT       exAluOp;
    logic        exRegWrite;
    logic        exMemRead;
    logic        exMemWrite;
    logic        exBranch;
    logic        exAluSrcImm;
    logic        exIllegal;

    modport master (
        output ifValid, ifInstr, ifPc, flush, regData1, regData2, exReady,
        input  ifReady, rAddr1, rAddr2, exValid, exPc, exRs1Data, exRs2Data, exImm, exDest,
               exAluOp, exRegWrite, exMemRead, exMemWrite, exBranch, exAluSrcImm, exIllegal
    );
    modport slave (
        input  ifValid, ifInstr, ifPc, flush, regData1, regData2, exReady,
        output ifReady, rAddr1, rAddr2, exValid, exPc, exRs1Data, exRs2Data, exImm, exDest,
               exAluOp, exRegWrite, exMemRead, exMemWrite, exBranch, exAluSrcImm, exIllegal
    );
endinterface

// File: rtl/decode_stage_ctrl.sv
// decode_ctrl: combinational MIPS decoder, instruction word to control bundle, immediate and source usage.
module decode_ctrl
    import mips_decode_pkg::*;
(
    input  logic [31:0] instr,
    output ctrlT        ctrl,
    output logic [31:0] imm,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic        usesRs,
    output logic        usesRt,
    output logic        illegal
);
    logic [5:0] op, funct;

    assign op    = instr[31:26];
    assign funct = instr[5:0];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];

    always_comb begin
        ctrl    = '0;
        imm     = signExt16(instr[15:0]);
        usesRs  = 1'b1;
        usesRt  = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_RTYPE: begin
                usesRt        = 1'b1;
                ctrl.regWrite = 1'b1;
                ctrl.dest     = instr[15:11];
                ctrl.aluOp    = funct == FN_SUB ? ALU_SUB :
                                funct == FN_AND ? ALU_AND :
                                funct == FN_OR  ? ALU_OR  :
                                funct == FN_SLT ? ALU_SLT : ALU_ADD;
                illegal       = !(funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT});
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_LW: begin
                ctrl.regWrite  = 1'b1;
                ctrl.aluSrcImm = 1'b1;
                ctrl.dest      = rt;
                ctrl.memRead   = op == OP_LW;
                ctrl.aluOp     = op == OP_ANDI ? ALU_AND :
                                 op == OP_ORI  ? ALU_OR  :
                                 op == OP_LUI  ? ALU_LUI : ALU_ADD;
                imm            = op == OP_LUI ? {instr[15:0], 16'h0} :
                                 op inside {OP_ANDI, OP_ORI} ? {16'h0, instr[15:0]} : imm;
                usesRs         = op != OP_LUI;
            end
            OP_SW: begin
                usesRt         = 1'b1;
                ctrl.memWrite  = 1'b1;
                ctrl.aluSrcImm = 1'b1;
            end
            OP_BEQ: begin
                usesRt      = 1'b1;
                ctrl.branch = 1'b1;
                ctrl.aluOp  = ALU_SUB;
            end
            default: illegal = 1'b1;
        endcase
        // Illegal words decode as a NOP: no writes, no memory, no sources
        if (illegal) begin
            ctrl   = '0;
            usesRs = 1'b0;
            usesRt = 1'b0;
        end
    end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: MIPS ID stage with ID latch, load-use stall, flush and ID/EX register (optional DECODE_ILLEGAL_TRAP_EN).
module decode_stage
    import mips_decode_pkg::*;
(
    input logic           clk,
    input logic           rst,
    decode_stage_if.slave bus
);
`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    logic        idFull, exValid, exIllegal;
    logic [31:0] idInstr, idPc, imm, exPc, exRs1, exRs2, exImm;
    logic [4:0]  rs, rt;
    logic        usesRs, usesRt, illegal, hazard, idAdvance, take;
    ctrlT        ctrl, exCtrl;

    decode_ctrl u_ctrl (
        .instr  (idInstr),
        .ctrl   (ctrl),
        .imm    (imm),
        .rs     (rs),
        .rt     (rt),
        .usesRs (usesRs),
        .usesRt (usesRt),
        .illegal(illegal)
    );

    assign hazard = idFull & exValid & exCtrl.memRead & (exCtrl.dest != 5'd0) &
                    ((usesRs & (exCtrl.dest == rs)) | (usesRt & (exCtrl.dest == rt)));
    assign idAdvance   = idFull & !hazard & (!exValid | bus.exReady) & !bus.flush;
    assign bus.ifReady = !bus.flush & (!idFull | idAdvance);
    assign take        = bus.ifValid & bus.ifReady;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idFull  <= 1'b0;
            idInstr <= '0;
            idPc    <= '0;
        end else if (bus.flush) begin
            idFull <= 1'b0;
        end else if (take) begin
            idFull  <= 1'b1;
            idInstr <= bus.ifInstr;
            idPc    <= bus.ifPc;
        end else if (idAdvance) begin
            idFull <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exValid   <= 1'b0;
            exCtrl    <= '0;
            exPc      <= '0;
            exRs1     <= '0;
            exRs2     <= '0;
            exImm     <= '0;
            exIllegal <= 1'b0;
        end else if (bus.flush) begin
            exValid <= 1'b0;
        end else if (idAdvance) begin
            exValid   <= 1'b1;
            exCtrl    <= ctrl;
            exPc      <= idPc;
            exRs1     <= bus.regData1;
            exRs2     <= bus.regData2;
            exImm     <= imm;
            exIllegal <= TRAP & illegal;
        end else if (bus.exReady) begin
            exValid <= 1'b0;
        end
    end

    assign bus.rAddr1      = rs;
    assign bus.rAddr2      = rt;
    assign bus.exValid     = exValid;
    assign bus.exPc        = exPc;
    assign bus.exRs1Data   = exRs1;
    assign bus.exRs2Data   = exRs2;
    assign bus.exImm       = exImm;
    assign bus.exDest      = exCtrl.dest;
    assign bus.exAluOp     = exCtrl.aluOp;
    assign bus.exRegWrite  = exCtrl.regWrite;
    assign bus.exMemRead   = exCtrl.memRead;
    assign bus.exMemWrite  = exCtrl.memWrite;
    assign bus.exBranch    = exCtrl.branch;
    assign bus.exAluSrcImm = exCtrl.aluSrcImm;
    assign bus.exIllegal   = exIllegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors into decode_stage, scoreboard queue checked by a monitor on ID/EX consumption.
module tb_decode_stage;
    import mips_decode_pkg::*;

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc, rs1, rs2, imm;
        logic        immCare;
        logic [4:0]  dest;
        logic [3:0]  alu;
        logic [5:0]  flags;
    } expT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_stage_if bus();
    decode_stage dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] bank [32];
    assign bus.regData1 = bank[bus.rAddr1];
    assign bus.regData2 = bank[bus.rAddr2];

    expT         sb [$];
    expT         got;
    int          total = 0;
    int          bad = 0;
    logic [31:0] pcNext = 32'h100;
    logic [31:0] pcHold;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // flags = {regWrite, memRead, memWrite, branch, aluSrcImm, illegal}
    function automatic expT mk(input logic [31:0] rs1, rs2, imm, input logic immCare,
                               input logic [4:0] dest, input aluOpT alu, input logic [5:0] flags);
        expT e;
        e.pc = '0; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.immCare = immCare;
        e.dest = dest; e.alu = alu; e.flags = flags;
        return e;
    endfunction

    task automatic send(input logic [31:0] instr, input expT e, input logic push);
        logic done = 1'b0;
        bus.ifValid = 1'b1;
        bus.ifInstr = instr;
        bus.ifPc    = pcNext;
        e.pc        = pcNext;
        if (push) sb.push_back(e);
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.ifReady) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL accept timeout: instr %h never accepted", instr);
        end
        bus.ifValid = 1'b0;
        pcNext += 4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.exValid && bus.exReady) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected output: pc %h", bus.exPc);
            end else begin
                got = sb.pop_front();
                chk("exPc", bus.exPc, got.pc);
                chk("exRs1Data", bus.exRs1Data, got.rs1);
                chk("exRs2Data", bus.exRs2Data, got.rs2);
                if (got.immCare) chk("exImm", bus.exImm, got.imm);
                chk("exDest", 32'(bus.exDest), 32'(got.dest));
                chk("exAluOp", 32'(bus.exAluOp), 32'(got.alu));
                chk("ctrlFlags", 32'({bus.exRegWrite, bus.exMemRead, bus.exMemWrite, bus.exBranch,
                                      bus.exAluSrcImm, bus.exIllegal}), 32'(got.flags));
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) bank[i] = 32'h1000 + i;
        bank[0] = 32'h0;
        bank[1] = 32'd5;
        bank[2] = 32'd7;
        bus.ifValid = 1'b0;
        bus.ifInstr = '0;
        bus.ifPc    = '0;
        bus.flush   = 1'b0;
        bus.exReady = 1'b1;
        #1;
        chk("rst exValid", 32'(bus.exValid), 0);
        chk("rst exPc", bus.exPc, 0);
        chk("rst exImm", bus.exImm, 0);
        chk("rst ctrl", 32'({bus.exDest, bus.exAluOp, bus.exRegWrite, bus.exMemRead, bus.exMemWrite,
                             bus.exBranch, bus.exAluSrcImm, bus.exIllegal}), 0);
        chk("rst rAddr", 32'({bus.rAddr1, bus.rAddr2}), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("ifReady after rst", 32'(bus.ifReady), 1);

        // add $3,$1,$2 and two-edge latency
        send(32'h00221820, mk(5, 7, 32'h1820, 1, 3, ALU_ADD, 6'b100000), 1);
        chk("lat exValid early", 32'(bus.exValid), 0);
        tick();
        chk("lat exValid", 32'(bus.exValid), 1);
        chk("lat exDest", 32'(bus.exDest), 3);
        repeat (2) tick();

        // addi $4,$0,-1 ; ori $5,$0,0xFFFF back-to-back
        send(32'h2004FFFF, mk(0, 32'h1004, 32'hFFFFFFFF, 1, 4, ALU_ADD, 6'b100010), 1);
        chk("throughput ifReady", 32'(bus.ifReady), 1);
        send(32'h3405FFFF, mk(0, 32'h1005, 32'h0000FFFF, 1, 5, ALU_OR, 6'b100010), 1);
        repeat (3) tick();

        // lw $2,0($1) ; add $3,$2,$2 -> one bubble
        send(32'h8C220000, mk(5, 7, 0, 1, 2, ALU_ADD, 6'b110010), 1);
        send(32'h00421820, mk(7, 7, 32'h1820, 1, 3, ALU_ADD, 6'b100000), 1);
        chk("lu ifReady stall", 32'(bus.ifReady), 0);
        chk("lu exMemRead", 32'(bus.exMemRead), 1);
        tick();
        chk("lu bubble", 32'(bus.exValid), 0);
        chk("lu ifReady resume", 32'(bus.ifReady), 1);
        tick();
        chk("lu add valid", 32'(bus.exValid), 1);
        chk("lu add dest", 32'(bus.exDest), 3);
        repeat (3) tick();

        // backpressure: sub held 3 cycles while or waits in ID
        bus.exReady = 1'b0;
        pcHold = pcNext;
        send(32'h00223022, mk(5, 7, 32'h3022, 1, 6, ALU_SUB, 6'b100000), 1);
        send(32'h00223825, mk(5, 7, 32'h3825, 1, 7, ALU_OR, 6'b100000), 1);
        for (int k = 0; k < 3; k++) begin
            chk("bp exValid", 32'(bus.exValid), 1);
            chk("bp exPc", bus.exPc, pcHold);
            chk("bp exAluOp", 32'(bus.exAluOp), 32'(ALU_SUB));
            chk("bp exRs1Data", bus.exRs1Data, 5);
            chk("bp ifReady", 32'(bus.ifReady), 0);
            tick();
        end
        bus.exReady = 1'b1;
        repeat (4) tick();

        // flush with ID and ID/EX both full; concurrent fetch dropped
        bus.exReady = 1'b0;
        send(32'h00224024, mk(0, 0, 0, 0, 0, ALU_ADD, 0), 0);
        send(32'h302900F0, mk(0, 0, 0, 0, 0, ALU_ADD, 0), 0);
        chk("pre-flush idFull", 32'(dut.idFull), 1);
        bus.flush   = 1'b1;
        bus.ifValid = 1'b1;
        bus.ifInstr = 32'h3C0A1234;
        #1 chk("flush ifReady", 32'(bus.ifReady), 0);
        @(posedge clk);
        #1;
        bus.flush   = 1'b0;
        bus.ifValid = 1'b0;
        chk("flush exValid", 32'(bus.exValid), 0);
        chk("flush idFull", 32'(dut.idFull), 0);
        bus.exReady = 1'b1;
        repeat (3) begin
            tick();
            chk("flush drop", 32'(bus.exValid), 0);
        end

        // remaining opcodes and illegal words
        send(32'h1022FFFC, mk(5, 7, 32'hFFFFFFFC, 1, 0, ALU_SUB, 6'b000100), 1);
        send(32'h3C0A1234, mk(0, 32'h100A, 32'h12340000, 1, 10, ALU_LUI, 6'b100010), 1);
        send(32'hAC220004, mk(5, 7, 32'h4, 1, 0, ALU_ADD, 6'b001010), 1);
        send(32'h0022582A, mk(5, 7, 32'h582A, 1, 11, ALU_SLT, 6'b100000), 1);
        send(32'hFC221820, mk(5, 7, 0, 0, 0, ALU_ADD, {5'b0, TRAP}), 1);
        send(32'h00225821, mk(5, 7, 0, 0, 0, ALU_ADD, {5'b0, TRAP}), 1);

        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        chk("scoreboard drained", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
